fc_init_sequencer: RTL and testbench

Per-VC Data Link Layer flow-control initialisation sequencer for the PCIe link layer. It drives the FC_INIT1 and FC_INIT2 phases, transmitting InitFC1 and InitFC2 DLLP triplets (P, NP, Cpl) through a valid/ack handshake to the DLLP transmit mux. It captures the peer's advertised credits from decoded InitFC DLLPs and asserts `fc_init_done` when the VC may carry TLPs. One instance is used per enabled VC, and it sits beside the InitFC DLLP decoder.

---
 rtl/fc_init_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 tb/tb_fc_init_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_init_sequencer.sv
// -----------------------------------------------------------------------------
// fc_init_sequencer
//
// Per-VC Data Link Layer flow-control initialisation sequencer. It walks the
// FC_INIT1 and FC_INIT2 phases and sends InitFC1/InitFC2 DLLP triplets
// (P, NP, Cpl) to the DLLP transmit mux over a req/ack handshake. It also
// captures the credits the peer advertises, and raises fc_init_done once the
// VC may carry TLPs.
//
// Optional feature macro: FC_INIT_TIMEOUT_EN
//   defined   : a watchdog limits the total time spent in the FC1/FC2 states to
//               TIMEOUT_CYCLES. On expiry, fc_init_err pulses and the sequence
//               restarts from IDLE with everything cleared.
//   undefined : no watchdog is built and fc_init_err is tied low.
//
// Ports
//   clk, rst        : clock and synchronous active-high reset
//   link_up         : DL_Up request (level). Low forces IDLE and clears state.
//   rx_fc_valid     : one-cycle strobe for a decoded InitFC/UpdateFC DLLP
//   rx_fc_kind      : 00 InitFC1, 01 InitFC2, 10 UpdateFC, 11 ignored
//   rx_fc_class     : 00 P, 01 NP, 10 Cpl, 11 ignored
//   rx_vc           : VC of the received DLLP
//   rx_hdr_fc/rx_data_fc : received credit fields
//   tx_req/tx_ack   : transmit handshake (tx_req and tx fields are registered)
//   tx_stage        : 0 InitFC1, 1 InitFC2
//   tx_class        : 00 P, 01 NP, 10 Cpl
//   tx_vc           : constant VC_ID
//   tx_hdr_fc/tx_data_fc : local credits for tx_class
//   rem_*           : captured peer credits per class
//   fc_init_done    : FC init complete (level)
//   fc_init_err     : watchdog expiry pulse
//
// State table
//   state     | meaning
//   IDLE      | link down or just reset; waiting for link_up
//   FC1_SEND  | presenting InitFC1 triplet, one class per ack
//   FC1_WAIT  | resend gap; leave early once all FC1 flags are set
//   FC2_SEND  | presenting InitFC2 triplet, one class per ack
//   FC2_WAIT  | resend gap; leave early once fc2_seen is set
//   DONE      | flow control initialised, VC usable
// -----------------------------------------------------------------------------
module fc_init_sequencer #(
    parameter logic [2:0]  VC_ID          = 3'd0,
    parameter logic [7:0]  P_HDR          = 8'd32,
    parameter logic [11:0] P_DATA         = 12'd256,
    parameter logic [7:0]  NP_HDR         = 8'd32,
    parameter logic [11:0] NP_DATA        = 12'd32,
    parameter logic [7:0]  CPL_HDR        = 8'd0,
    parameter logic [11:0] CPL_DATA       = 12'd0,
    parameter logic [15:0] RESEND_CYCLES  = 16'd1000,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        link_up,
    input  logic        rx_fc_valid,
    input  logic [1:0]  rx_fc_kind,
    input  logic [1:0]  rx_fc_class,
    input  logic [2:0]  rx_vc,
    input  logic [7:0]  rx_hdr_fc,
    input  logic [11:0] rx_data_fc,
    output logic        tx_req,
    input  logic        tx_ack,
    output logic        tx_stage,
    output logic [1:0]  tx_class,
    output logic [2:0]  tx_vc,
    output logic [7:0]  tx_hdr_fc,
    output logic [11:0] tx_data_fc,
    output logic [7:0]  rem_p_hdr,
    output logic [11:0] rem_p_data,
    output logic [7:0]  rem_np_hdr,
    output logic [11:0] rem_np_data,
    output logic [7:0]  rem_cpl_hdr,
    output logic [11:0] rem_cpl_data,
    output logic        fc_init_done,
    output logic        fc_init_err
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FC1_SEND = 3'd1,
        ST_FC1_WAIT = 3'd2,
        ST_FC2_SEND = 3'd3,
        ST_FC2_WAIT = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    localparam logic [1:0] CLS_P   = 2'd0;
    localparam logic [1:0] CLS_NP  = 2'd1;
    localparam logic [1:0] CLS_CPL = 2'd2;

    localparam logic [1:0] KIND_INIT1  = 2'd0;
    localparam logic [1:0] KIND_INIT2  = 2'd1;
    localparam logic [1:0] KIND_UPDATE = 2'd2;

    // The timer counts down to zero; loading N-1 yields exactly N wait cycles.
    localparam logic [15:0] RESEND_LOAD =
        (RESEND_CYCLES == 16'd0) ? 16'd0 : RESEND_CYCLES - 16'd1;

    state_t      state, state_nxt;
    logic [1:0]  cls, cls_nxt;
    logic [15:0] timer, timer_nxt;
    logic [2:0]  fc1_flags;
    logic        fc1_all;
    logic        fc2_seen;
    logic        abort;
    logic        wd_expire;
    logic        send_nxt;
    logic        in_fc2;
    logic        rx_hit;
    logic        rx_is_init;
    logic        rx_counts_fc2;
    logic        rx_flag_set;

    function automatic logic [7:0] hdr_of(input logic [1:0] c);
        case (c)
            CLS_P:   hdr_of = P_HDR;
            CLS_NP:  hdr_of = NP_HDR;
            CLS_CPL: hdr_of = CPL_HDR;
            default: hdr_of = 8'd0;
        endcase
    endfunction

    function automatic logic [11:0] data_of(input logic [1:0] c);
        case (c)
            CLS_P:   data_of = P_DATA;
            CLS_NP:  data_of = NP_DATA;
            CLS_CPL: data_of = CPL_DATA;
            default: data_of = 12'd0;
        endcase
    endfunction

    assign tx_vc   = VC_ID;
    assign fc1_all = &fc1_flags;
    assign in_fc2  = (state == ST_FC2_SEND) || (state == ST_FC2_WAIT);
    assign abort   = !link_up || wd_expire;

    // -------------------------------------------------------------------------
    // Watchdog
    // -------------------------------------------------------------------------
`ifdef FC_INIT_TIMEOUT_EN
    localparam logic [23:0] WD_LOAD =
        (TIMEOUT_CYCLES == 24'd0) ? 24'd0 : TIMEOUT_CYCLES - 24'd1;

    logic [23:0] wd_cnt;
    logic        wd_active;

    assign wd_active = (state == ST_FC1_SEND) || (state == ST_FC1_WAIT) ||
                       (state == ST_FC2_SEND) || (state == ST_FC2_WAIT);
    assign wd_expire = wd_active && (wd_cnt == 24'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt      <= WD_LOAD;
            fc_init_err <= 1'b0;
        end else begin
            fc_init_err <= wd_expire;
            if (!wd_active || wd_expire) begin
                wd_cnt <= WD_LOAD;
            end else begin
                wd_cnt <= wd_cnt - 24'd1;
            end
        end
    end
`else
    assign wd_expire   = 1'b0;
    assign fc_init_err = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cls_nxt   = cls;
        timer_nxt = timer;

        case (state)
            ST_IDLE: begin
                if (link_up) begin
                    state_nxt = ST_FC1_SEND;
                    cls_nxt   = CLS_P;
                end
            end
            ST_FC1_SEND: begin
                if (tx_ack) begin
                    if (cls >= CLS_CPL) begin
                        // Triplet boundary: the only point the phase may change.
                        cls_nxt = CLS_P;
                        if (fc1_all) begin
                            state_nxt = ST_FC2_SEND;
                        end else begin
                            state_nxt = ST_FC1_WAIT;
                            timer_nxt = RESEND_LOAD;
                        end
                    end else begin
                        cls_nxt = cls + 2'd1;
                    end
                end
            end
            ST_FC1_WAIT: begin
                if (fc1_all) begin
                    state_nxt = ST_FC2_SEND;
                    cls_nxt   = CLS_P;
                end else if (timer == 16'd0) begin
                    state_nxt = ST_FC1_SEND;
                    cls_nxt   = CLS_P;
                end else begin
                    timer_nxt = timer - 16'd1;
                end
            end
            ST_FC2_SEND: begin
                if (tx_ack) begin
                    if (cls >= CLS_CPL) begin
                        cls_nxt = CLS_P;
                        if (fc2_seen) begin
                            state_nxt = ST_DONE;
                        end else begin
                            state_nxt = ST_FC2_WAIT;
                            timer_nxt = RESEND_LOAD;
                        end
                    end else begin
                        cls_nxt = cls + 2'd1;
                    end
                end
            end
            ST_FC2_WAIT: begin
                if (fc2_seen) begin
                    state_nxt = ST_DONE;
                end else if (timer == 16'd0) begin
                    state_nxt = ST_FC2_SEND;
                    cls_nxt   = CLS_P;
                end else begin
                    timer_nxt = timer - 16'd1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_DONE;
            end
            default: begin
                state_nxt = ST_IDLE;
                cls_nxt   = CLS_P;
            end
        endcase

        if (abort) begin
            state_nxt = ST_IDLE;
            cls_nxt   = CLS_P;
            timer_nxt = 16'd0;
        end
    end

    assign send_nxt = (state_nxt == ST_FC1_SEND) || (state_nxt == ST_FC2_SEND);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cls   <= CLS_P;
            timer <= 16'd0;
        end else begin
            state <= state_nxt;
            cls   <= cls_nxt;
            timer <= timer_nxt;
        end
    end

    // Transmit fields are registered from the next-state view, so they change
    // only on the cycle after an ack and hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_req       <= 1'b0;
            tx_stage     <= 1'b0;
            tx_class     <= CLS_P;
            tx_hdr_fc    <= 8'd0;
            tx_data_fc   <= 12'd0;
            fc_init_done <= 1'b0;
        end else begin
            tx_req       <= send_nxt;
            tx_stage     <= (state_nxt == ST_FC2_SEND);
            tx_class     <= send_nxt ? cls_nxt : CLS_P;
            tx_hdr_fc    <= send_nxt ? hdr_of(cls_nxt) : 8'd0;
            tx_data_fc   <= send_nxt ? data_of(cls_nxt) : 12'd0;
            fc_init_done <= (state_nxt == ST_DONE);
        end
    end

    // -------------------------------------------------------------------------
    // Receive path
    // -------------------------------------------------------------------------
    assign rx_hit = rx_fc_valid && (rx_vc == VC_ID) &&
                    (rx_fc_kind != 2'b11) && (rx_fc_class != 2'b11);
    assign rx_is_init    = (rx_fc_kind == KIND_INIT1) || (rx_fc_kind == KIND_INIT2);
    assign rx_counts_fc2 = (rx_fc_kind == KIND_INIT2) || (rx_fc_kind == KIND_UPDATE);

    always_comb begin
        rx_flag_set = 1'b1;
        case (rx_fc_class)
            CLS_P:   rx_flag_set = fc1_flags[0];
            CLS_NP:  rx_flag_set = fc1_flags[1];
            CLS_CPL: rx_flag_set = fc1_flags[2];
            default: rx_flag_set = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            fc1_flags    <= 3'b000;
            fc2_seen     <= 1'b0;
            rem_p_hdr    <= 8'd0;
            rem_p_data   <= 12'd0;
            rem_np_hdr   <= 8'd0;
            rem_np_data  <= 12'd0;
            rem_cpl_hdr  <= 8'd0;
            rem_cpl_data <= 12'd0;
        end else if (rx_hit) begin
            // First advertisement per class wins; duplicates are dropped.
            if (rx_is_init && !rx_flag_set) begin
                case (rx_fc_class)
                    CLS_P: begin
                        fc1_flags[0] <= 1'b1;
                        rem_p_hdr    <= rx_hdr_fc;
                        rem_p_data   <= rx_data_fc;
                    end
                    CLS_NP: begin
                        fc1_flags[1] <= 1'b1;
                        rem_np_hdr   <= rx_hdr_fc;
                        rem_np_data  <= rx_data_fc;
                    end
                    CLS_CPL: begin
                        fc1_flags[2] <= 1'b1;
                        rem_cpl_hdr  <= rx_hdr_fc;
                        rem_cpl_data <= rx_data_fc;
                    end
                    default: ;
                endcase
            end
            // InitFC2/UpdateFC seen during FC1 must not count toward FC2 exit.
            if (rx_counts_fc2 && in_fc2) begin
                fc2_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fc_init_sequencer.sv
module tb_fc_init_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        link_up;
    logic        rx_fc_valid;
    logic [1:0]  rx_fc_kind;
    logic [1:0]  rx_fc_class;
    logic [2:0]  rx_vc;
    logic [7:0]  rx_hdr_fc;
    logic [11:0] rx_data_fc;
    logic        tx_req;
    logic        tx_ack;
    logic        tx_stage;
    logic [1:0]  tx_class;
    logic [2:0]  tx_vc;
    logic [7:0]  tx_hdr_fc;
    logic [11:0] tx_data_fc;
    logic [7:0]  rem_p_hdr, rem_np_hdr, rem_cpl_hdr;
    logic [11:0] rem_p_data, rem_np_data, rem_cpl_data;
    logic        fc_init_done;
    logic        fc_init_err;

    int n_pass  = 0;
    int n_total = 0;
    logic err_seen = 1'b0;

    // Expected tx vectors {req, stage, class, hdr, data}
    localparam logic [23:0] TX_FC1_P   = {1'b1, 1'b0, 2'd0, 8'd32, 12'd256};
    localparam logic [23:0] TX_FC1_NP  = {1'b1, 1'b0, 2'd1, 8'd32, 12'd32};
    localparam logic [23:0] TX_FC1_CPL = {1'b1, 1'b0, 2'd2, 8'd0,  12'd0};
    localparam logic [23:0] TX_FC2_P   = {1'b1, 1'b1, 2'd0, 8'd32, 12'd256};
    localparam logic [23:0] TX_FC2_NP  = {1'b1, 1'b1, 2'd1, 8'd32, 12'd32};
    localparam logic [23:0] TX_FC2_CPL = {1'b1, 1'b1, 2'd2, 8'd0,  12'd0};

    wire [23:0] tx_vec  = {tx_req, tx_stage, tx_class, tx_hdr_fc, tx_data_fc};
    wire [59:0] rem_vec = {rem_p_hdr, rem_p_data, rem_np_hdr, rem_np_data,
                           rem_cpl_hdr, rem_cpl_data};

    fc_init_sequencer #(
        .VC_ID          (3'd0),
        .P_HDR          (8'd32),
        .P_DATA         (12'd256),
        .NP_HDR         (8'd32),
        .NP_DATA        (12'd32),
        .CPL_HDR        (8'd0),
        .CPL_DATA       (12'd0),
        .RESEND_CYCLES  (16'd1000),
        .TIMEOUT_CYCLES (24'd5000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .link_up      (link_up),
        .rx_fc_valid  (rx_fc_valid),
        .rx_fc_kind   (rx_fc_kind),
        .rx_fc_class  (rx_fc_class),
        .rx_vc        (rx_vc),
        .rx_hdr_fc    (rx_hdr_fc),
        .rx_data_fc   (rx_data_fc),
        .tx_req       (tx_req),
        .tx_ack       (tx_ack),
        .tx_stage     (tx_stage),
        .tx_class     (tx_class),
        .tx_vc        (tx_vc),
        .tx_hdr_fc    (tx_hdr_fc),
        .tx_data_fc   (tx_data_fc),
        .rem_p_hdr    (rem_p_hdr),
        .rem_p_data   (rem_p_data),
        .rem_np_hdr   (rem_np_hdr),
        .rem_np_data  (rem_np_data),
        .rem_cpl_hdr  (rem_cpl_hdr),
        .rem_cpl_data (rem_cpl_data),
        .fc_init_done (fc_init_done),
        .fc_init_err  (fc_init_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fc_init_err === 1'b1) err_seen <= 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rx();
        rx_fc_valid = 1'b0;
        rx_fc_kind  = 2'd0;
        rx_fc_class = 2'd0;
        rx_vc       = 3'd0;
        rx_hdr_fc   = 8'd0;
        rx_data_fc  = 12'd0;
    endtask

    task automatic send_rx(input logic [1:0] kind, input logic [1:0] c,
                           input logic [2:0] vc, input logic [7:0] hdr,
                           input logic [11:0] data);
        rx_fc_valid = 1'b1;
        rx_fc_kind  = kind;
        rx_fc_class = c;
        rx_vc       = vc;
        rx_hdr_fc   = hdr;
        rx_data_fc  = data;
    endtask

    task automatic test_reset();
        rst = 1'b1; link_up = 1'b1; tx_ack = 1'b0; clear_rx();
        tick(); tick();
        n_total++;
        if (tx_vec !== 24'd0) $display("FAIL reset_tx: got %h expected %h", tx_vec, 24'd0);
        else n_pass++;
        n_total++;
        if (tx_vc !== 3'd0) $display("FAIL reset_vc: got %0d expected 0", tx_vc);
        else n_pass++;
        n_total++;
        if ({fc_init_done, fc_init_err} !== 2'b00)
            $display("FAIL reset_flags: got %b expected 00", {fc_init_done, fc_init_err});
        else n_pass++;
        n_total++;
        if (rem_vec !== 60'd0) $display("FAIL reset_rem: got %h expected 0", rem_vec);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_fc1_resend();
        int  gap;
        logic done_bad;
        tx_ack = 1'b1;
        tick();
        n_total++;
        if (tx_vec !== TX_FC1_P) $display("FAIL fc1_p: got %h expected %h", tx_vec, TX_FC1_P);
        else n_pass++;
        tick();
        n_total++;
        if (tx_vec !== TX_FC1_NP) $display("FAIL fc1_np: got %h expected %h", tx_vec, TX_FC1_NP);
        else n_pass++;
        tick();
        n_total++;
        if (tx_vec !== TX_FC1_CPL) $display("FAIL fc1_cpl: got %h expected %h", tx_vec, TX_FC1_CPL);
        else n_pass++;
        tick();
        gap = 0; done_bad = 1'b0;
        while (tx_req === 1'b0 && gap < 2000) begin
            gap++;
            if (fc_init_done !== 1'b0) done_bad = 1'b1;
            tick();
        end
        n_total++;
        if (gap != 1000) $display("FAIL resend_gap: got %0d expected 1000", gap);
        else n_pass++;
        n_total++;
        if (done_bad !== 1'b0) $display("FAIL done_in_fc1: got %b expected 0", done_bad);
        else n_pass++;
        n_total++;
        if (tx_vec !== TX_FC1_P) $display("FAIL resend_p: got %h expected %h", tx_vec, TX_FC1_P);
        else n_pass++;
    endtask

    task automatic test_capture();
        send_rx(2'd0, 2'd0, 3'd0, 8'd10, 12'h040); tick();
        send_rx(2'd0, 2'd1, 3'd0, 8'd4,  12'h008); tick();
        send_rx(2'd1, 2'd2, 3'd0, 8'd0,  12'h000); tick();
        clear_rx();
        // Cpl arrived with the Cpl ack, so that boundary still falls into FC1_WAIT
        n_total++;
        if (tx_req !== 1'b0) $display("FAIL same_cycle_boundary: got tx_req %b expected 0", tx_req);
        else n_pass++;
        n_total++;
        if (rem_vec !== {8'd10, 12'h040, 8'd4, 12'h008, 8'd0, 12'h000})
            $display("FAIL capture_rem: got %h expected %h", rem_vec,
                     {8'd10, 12'h040, 8'd4, 12'h008, 8'd0, 12'h000});
        else n_pass++;
        tick();
        n_total++;
        if (tx_vec !== TX_FC2_P) $display("FAIL fc2_start: got %h expected %h", tx_vec, TX_FC2_P);
        else n_pass++;
    endtask

    task automatic test_duplicate();
        send_rx(2'd0, 2'd0, 3'd0, 8'd99, 12'h099); tick();
        send_rx(2'd2, 2'd0, 3'd3, 8'd77, 12'h077); tick();
        clear_rx();
        n_total++;
        if (tx_vec !== TX_FC2_CPL) $display("FAIL fc2_cpl: got %h expected %h", tx_vec, TX_FC2_CPL);
        else n_pass++;
        n_total++;
        if ({rem_p_hdr, rem_p_data} !== {8'd10, 12'h040})
            $display("FAIL dup_rem_p: got %h expected %h", {rem_p_hdr, rem_p_data}, {8'd10, 12'h040});
        else n_pass++;
        tick();
        n_total++;
        if ({tx_req, fc_init_done} !== 2'b00)
            $display("FAIL fc2_wait_entry: got %b expected 00", {tx_req, fc_init_done});
        else n_pass++;
    endtask

    task automatic test_done();
        logic bad;
        send_rx(2'b11, 2'd0, 3'd0, 8'd1, 12'h001); tick();
        clear_rx(); tick();
        n_total++;
        if (fc_init_done !== 1'b0) $display("FAIL kind11_ignored: got done %b expected 0", fc_init_done);
        else n_pass++;
        send_rx(2'd2, 2'd0, 3'd0, 8'd0, 12'h000); tick();
        clear_rx();
        n_total++;
        if (fc_init_done !== 1'b0) $display("FAIL done_early: got %b expected 0", fc_init_done);
        else n_pass++;
        tick();
        n_total++;
        if ({fc_init_done, tx_req} !== 2'b10)
            $display("FAIL done_from_wait: got %b expected 10", {fc_init_done, tx_req});
        else n_pass++;
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if ({fc_init_done, tx_req} !== 2'b10) bad = 1'b1;
        end
        n_total++;
        if (bad !== 1'b0) $display("FAIL done_hold: got bad %b expected 0", bad);
        else n_pass++;
    endtask

    task automatic test_link_drop();
        link_up = 1'b0;
        tick();
        n_total++;
        if ({tx_req, fc_init_done} !== 2'b00)
            $display("FAIL drop_outputs: got %b expected 00", {tx_req, fc_init_done});
        else n_pass++;
        n_total++;
        if (rem_vec !== 60'd0) $display("FAIL drop_rem: got %h expected 0", rem_vec);
        else n_pass++;
    endtask

    task automatic test_ack_stall();
        logic bad;
        link_up = 1'b1; tx_ack = 1'b1;
        tick(); tick();
        tx_ack = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 0)      send_rx(2'd1, 2'd0, 3'd0, 8'd5, 12'h010);
            else if (i == 1) send_rx(2'd0, 2'd1, 3'd0, 8'd3, 12'h003);
            else if (i == 2) send_rx(2'd0, 2'd2, 3'd0, 8'd1, 12'h001);
            else             clear_rx();
            tick();
            if (tx_vec !== TX_FC1_NP) bad = 1'b1;
        end
        clear_rx();
        n_total++;
        if (bad !== 1'b0) $display("FAIL stall_stable: got bad %b expected 0", bad);
        else n_pass++;
        n_total++;
        if (rem_vec !== {8'd5, 12'h010, 8'd3, 12'h003, 8'd1, 12'h001})
            $display("FAIL stall_rem: got %h expected %h", rem_vec,
                     {8'd5, 12'h010, 8'd3, 12'h003, 8'd1, 12'h001});
        else n_pass++;
        link_up = 1'b0;
        tick();
        n_total++;
        if ({tx_req, fc_init_done, rem_vec} !== 62'd0)
            $display("FAIL stall_drop: got req %b rem %h expected 0", tx_req, rem_vec);
        else n_pass++;
        tick(); tick(); tick();
        n_total++;
        if (tx_req !== 1'b0) $display("FAIL idle_hold: got %b expected 0", tx_req);
        else n_pass++;
        link_up = 1'b1;
        tick();
        n_total++;
        if (tx_vec !== TX_FC1_P) $display("FAIL restart_p: got %h expected %h", tx_vec, TX_FC1_P);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        send_rx(2'd0, 2'd0, 3'd0, 8'd7, 12'h070); tick();
        send_rx(2'd0, 2'd1, 3'd0, 8'd6, 12'h060); tick();
        send_rx(2'd0, 2'd2, 3'd0, 8'd5, 12'h050); tick();
        clear_rx();
        tx_ack = 1'b1;
        n_total++;
        if (tx_vec !== TX_FC1_P) $display("FAIL b2b_p_held: got %h expected %h", tx_vec, TX_FC1_P);
        else n_pass++;
        tick();
        n_total++;
        if (tx_vec !== TX_FC1_NP) $display("FAIL b2b_np: got %h expected %h", tx_vec, TX_FC1_NP);
        else n_pass++;
        tick();
        n_total++;
        if (tx_vec !== TX_FC1_CPL) $display("FAIL b2b_cpl: got %h expected %h", tx_vec, TX_FC1_CPL);
        else n_pass++;
        tick();
        n_total++;
        if (tx_vec !== TX_FC2_P) $display("FAIL b2b_direct_fc2: got %h expected %h", tx_vec, TX_FC2_P);
        else n_pass++;
        send_rx(2'd2, 2'd1, 3'd0, 8'd0, 12'h000); tick();
        clear_rx();
        n_total++;
        if (tx_vec !== TX_FC2_NP) $display("FAIL b2b_fc2_np: got %h expected %h", tx_vec, TX_FC2_NP);
        else n_pass++;
        tick(); tick();
        n_total++;
        if ({fc_init_done, tx_req} !== 2'b10)
            $display("FAIL done_after_cpl_ack: got %b expected 10", {fc_init_done, tx_req});
        else n_pass++;
        n_total++;
        if (rem_vec !== {8'd7, 12'h070, 8'd6, 12'h060, 8'd5, 12'h050})
            $display("FAIL b2b_rem: got %h expected %h", rem_vec,
                     {8'd7, 12'h070, 8'd6, 12'h060, 8'd5, 12'h050});
        else n_pass++;
    endtask

    task automatic test_watchdog();
`ifdef FC_INIT_TIMEOUT_EN
        int n;
        link_up = 1'b0; tick();
        link_up = 1'b1; tx_ack = 1'b1;
        n = 0;
        while (fc_init_err !== 1'b1 && n < 6000) begin
            tick();
            n++;
        end
        n_total++;
        if (n != 5001) $display("FAIL wd_cycle: got %0d expected 5001", n);
        else n_pass++;
        n_total++;
        if (tx_req !== 1'b0) $display("FAIL wd_idle: got %b expected 0", tx_req);
        else n_pass++;
        tick();
        n_total++;
        if ({fc_init_err, tx_vec} !== {1'b0, TX_FC1_P})
            $display("FAIL wd_restart: got err %b tx %h expected 0 %h", fc_init_err, tx_vec, TX_FC1_P);
        else n_pass++;
`else
        n_total++;
        if (err_seen !== 1'b0) $display("FAIL err_tied_low: got %b expected 0", err_seen);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_fc1_resend();
        test_capture();
        test_duplicate();
        test_done();
        test_link_drop();
        test_ack_stall();
        test_back_to_back();
        test_watchdog();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
